// File: rtl/wlmont_final_corr.sv
// Final correction after word-level Montgomery reduction: maps To in [0, 2q) to [0, q).
// Two-stage stallable valid/ready pipe with sideband tag and a sticky range-violation flag.
module wlmont_final_corr #(
    parameter int LOGQ  = 31,
    parameter int LOGTI = 32,
    parameter int TAGW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LOGQ-1:0]  q,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGTI-1:0] in_data,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             err,
    input  logic             err_clr
);

    localparam int XW = LOGTI + 1 - LOGQ;

    logic            s1_valid_q, s1_valid_d;
    logic [LOGQ-1:0] s1_lo_q, s1_lo_d;
    logic [LOGQ-1:0] s1_d1_q, s1_d1_d;
    logic            s1_ge1_q, s1_ge1_d;
    logic            s1_ge2_q, s1_ge2_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;
    logic            s2_valid_q, s2_valid_d;
    logic [LOGQ-1:0] out_data_q, out_data_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic            err_q, err_d;

    logic             adv1;
    logic             in_fire;
    logic             load2;
    logic [LOGTI:0]   d1;
    logic [LOGTI+1:0] d2;
    logic             unused_bits;

    assign adv1     = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv1;
    assign in_fire  = in_valid && in_ready;
    assign load2    = s1_valid_q && adv1;

    // The MSB of each widened difference is the borrow: set means in_data < subtrahend.
    assign d1 = {1'b0, in_data} - {{XW{1'b0}}, q};
    assign d2 = {2'b00, in_data} - {{XW{1'b0}}, q, 1'b0};

    assign unused_bits = ^{d1[LOGTI-1:LOGQ], d2[LOGTI:0]};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_d1_d    = s1_d1_q;
        s1_ge1_d   = s1_ge1_q;
        s1_ge2_d   = s1_ge2_q;
        s1_tag_d   = s1_tag_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = in_data[LOGQ-1:0];
            s1_d1_d    = d1[LOGQ-1:0];
            s1_ge1_d   = !d1[LOGTI];
            s1_ge2_d   = !d2[LOGTI+1];
            s1_tag_d   = in_tag;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        if (load2) begin
            s2_valid_d = 1'b1;
            out_data_d = s1_ge1_q ? s1_d1_q : s1_lo_q;
            out_tag_d  = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // A violation landing in stage 2 overrides a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (load2 && s1_ge2_q) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_d1_q    <= '0;
            s1_ge1_q   <= 1'b0;
            s1_ge2_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_d1_q    <= s1_d1_d;
            s1_ge1_q   <= s1_ge1_d;
            s1_ge2_q   <= s1_ge2_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wlmont_final_corr.sv
// Scoreboard bench for wlmont_final_corr: the driver pushes expected results on input
// transfer, a negedge monitor pops and compares on every output transfer.
module tb_wlmont_final_corr;

    logic        clk;
    logic        rst_n;
    logic [30:0] q;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out_data;
    logic [7:0]  out_tag;
    logic        err;
    logic        err_clr;

    wlmont_final_corr #(.LOGQ(31), .LOGTI(32), .TAGW(8)) dut (
        .clk(clk), .rst_n(rst_n), .q(q),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .err(err), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [30:0] d;
        logic [7:0]  t;
        logic [31:0] c;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  lat_chk = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {25'd0, out_data, out_tag}, 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("out_data", {33'd0, out_data}, {33'd0, e.d});
                chk("out_tag", {56'd0, out_tag}, {56'd0, e.t});
                if (lat_chk) chk("latency", 64'(cyc - int'(e.c)), 64'd2);
            end
        end
    end

    function automatic logic [30:0] ref_mod(input logic [31:0] d, input logic [30:0] qq);
        logic [63:0] dd, q1;
        dd = {32'd0, d};
        q1 = {33'd0, qq};
        if (dd < 2 * q1) return 31'(dd % q1);
        return 31'(dd - q1);
    endfunction

    task automatic send(input logic [31:0] d, input logic [7:0] t, input logic [30:0] e,
                        input bit push, output int stalls);
        stalls = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_tag = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) break;
            @(posedge clk); #1;
        end
        if (stalls > 50) chk("send_timeout", 64'd1, 64'd0);
        else if (push) sb.push_back('{d: e, t: t, c: 32'(cyc)});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (n < 200 && (sb.size() != 0 || out_valid)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, (n >= 200)}, 64'd0);
    endtask

    int st;

    initial begin
        logic [30:0] hold_d;
        logic [7:0]  hold_t;
        int tagc;

        rst_n = 1'b0; q = 31'h78000001; in_valid = 1'b0; in_data = '0; in_tag = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_out_data", {33'd0, out_data}, 64'd0);
        chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed boundary stream, no stall, with latency check
        lat_chk = 1;
        send(32'd5,          8'd1, 31'd5,          1, st);
        send(32'd2013265920, 8'd2, 31'd2013265920, 1, st);
        send(32'd2013265921, 8'd3, 31'd0,          1, st);
        send(32'd4026531841, 8'd4, 31'd2013265920, 1, st);
        idle();
        drain();
        lat_chk = 0;
        chk("err_after_stream", {63'd0, err}, 64'd0);

        // Same stream with a 4-cycle output stall after the first result
        fork
            begin
                send(32'd5,          8'd1, 31'd5,          1, st);
                send(32'd2013265920, 8'd2, 31'd2013265920, 1, st);
                send(32'd2013265921, 8'd3, 31'd0,          1, st);
                send(32'd4026531841, 8'd4, 31'd2013265920, 1, st);
                idle();
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 20);
                chk("first_out_seen", {63'd0, out_valid}, 64'd1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                hold_d = out_data;
                hold_t = out_tag;
                chk("full_in_ready", {63'd0, in_ready}, 64'd0);
                chk("full_out_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_tag_value", {56'd0, out_tag}, 64'd2);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("hold_data_stable", {33'd0, out_data}, {33'd0, hold_d});
                    chk("hold_tag_stable", {56'd0, out_tag}, {56'd0, hold_t});
                    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random valid / ready traffic over the full legal input range
        tagc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(1, 0));
            in_data   = $urandom_range(32'd4026531841, 0);
            in_tag    = 8'(tagc);
            out_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back('{d: ref_mod(in_data, q), t: 8'(tagc), c: 32'(cyc)});
                tagc++;
            end
        end
        idle();
        drain();
        chk("err_after_random", {63'd0, err}, 64'd0);

        // Range violation, clear, bubble immunity and set-wins-over-clear
        q = 31'd12289;
        send(32'd24578, 8'd10, 31'd12289, 1, st);
        idle();
        drain();
        chk("err_on_2q", {63'd0, err}, 64'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", {63'd0, err}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'd50000; in_tag = 8'hEE;
        repeat (4) @(negedge clk);
        chk("bubble_err", {63'd0, err}, 64'd0);
        chk("bubble_out_tag", {56'd0, out_tag}, 64'd10);
        chk("bubble_out_data", {33'd0, out_data}, 64'd12289);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'd30000; in_tag = 8'd11; err_clr = 1'b1;
        @(negedge clk);
        chk("viol_accept", {63'd0, in_ready}, 64'd1);
        sb.push_back('{d: 31'd17711, t: 8'd11, c: 32'(cyc)});
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_set_wins", {63'd0, err}, 64'd1);
        drain();

        // Asynchronous reset with two items in flight
        out_ready = 1'b0;
        send(32'd100, 8'd20, 31'd100, 0, st);
        send(32'd200, 8'd21, 31'd200, 0, st);
        idle();
        @(negedge clk);
        chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_err", {63'd0, err}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1;
        send(32'd7, 8'h77, 31'd7, 1, st);
        idle();
        drain();

        // 64 back-to-back inputs at full throughput
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = 32'(i * 211);
            send(v, 8'(i), (v >= 32'd12289) ? 31'(v - 32'd12289) : v[30:0], 1, st);
            chk("b2b_no_stall", 64'(st), 64'd0);
        end
        idle();
        drain();
        lat_chk = 0;
        chk("final_err", {63'd0, err}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wlmont_final_corr.md
Name: wlmont_final_corr

Overview:
- Output correction stage placed directly downstream of the last word-level Montgomery reduction subroutine.
- Takes the partially reduced value To, which lies in [0, 2q), and returns the canonical residue in [0, q).
- Provides a 2-stage stallable valid/ready pipeline with a sideband tag, so NTT butterfly and address metadata stays aligned with each datum.
- Flags any input that breaks the range contract (To >= 2q) through a sticky error bit.

Parameters:
- LOGQ, 31, bit-size of prime q.
- LOGTI, 32, width of the incoming reduction value. Must be >= LOGQ+1.
- TAGW, 8, width of the sideband tag carried with each datum.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q  input  LOGQ  prime modulus. Quasi-static: may change only while the pipe is empty.
- in_valid  input  1  input datum valid.
- in_ready  output  1  stage 1 can accept a datum.
- in_data  input  LOGTI  value To from the reduction stage.
- in_tag  input  TAGW  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  LOGQ  canonical residue in [0, q).
- out_tag  output  TAGW  tag belonging to out_data.
- err  output  1  sticky range-violation flag.
- err_clr  input  1  synchronous clear for err.

Behaviour:
- Reset (async assert, sync deassert handled externally) forces:
  - s1_valid = 0, s2_valid = 0, out_valid = 0, err = 0.
  - out_data = 0, out_tag = 0.
  - Data registers in stage 1 are don't-care.
- Reset asserted mid-operation discards all in-flight data. No output handshake occurs for those data.
- Handshake rules:
  - A transfer happens when valid && ready are both 1 in the same cycle.
  - in_ready = !s1_valid || adv1, where adv1 = !s2_valid || out_ready (stage 1 can move into stage 2).
  - in_ready is combinational from out_ready. There is no combinational path from in_valid to out_valid.
  - out_valid = s2_valid.
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
- Stage 1 (capture on in_valid && in_ready):
  - Register the tag.
  - d1 = in_data - q, computed at LOGTI+1 bits. ge1 = no borrow.
  - d2 = in_data - 2q, computed at LOGTI+2 bits. ge2 = no borrow.
  - Register in_data[LOGQ-1:0], d1[LOGQ-1:0], ge1 and ge2.
- Stage 2 (load when s1_valid && adv1):
  - out_data = ge1 ? d1[LOGQ-1:0] : in_data[LOGQ-1:0].
  - out_tag = stage-1 tag.
- Error on ge2=1:
  - Output still uses the single subtraction, so the result is in_data - q truncated to LOGQ bits.
  - err is set in the stage-2 load cycle.
- err behaviour:
  - Sticky until err_clr=1.
  - err_clr and a new violation in the same cycle: set wins.
- Latency: 2 cycles from input transfer to out_valid with no stall.
- Throughput: 1 per cycle while out_ready=1.
- Stage-1 occupancy on a cycle where s1_valid && adv1:
  - with simultaneous input transfer: s1_valid stays 1;
  - without input transfer: s1_valid becomes 0.
- Full condition: both stages valid and out_ready=0 gives in_ready=0. Pipeline holds exactly 2 data and nothing is lost.
- Empty condition: in_ready=1 and out_valid=0.
- Boundary values:
  - in_data = q-1 -> q-1.
  - in_data = q -> 0.
  - in_data = 2q-1 -> q-1.
  - Comparison is exact at the borrow boundary.
- Bubbles: invalid inputs never modify err, out_data or out_tag.

Test Plan:
- Reset, then q=2013265921 (0x78000001), stream in_data = 5, q-1, q, 2q-1 with tags 1..4 and out_ready=1 -> out_data = 5, 2013265920, 0, 2013265920, tags 1..4, each appearing 2 cycles after its input. err stays 0.
- Same stream with out_ready held 0 for 4 cycles after the first output -> in_ready drops after 2 accepted items. out_data and out_tag are stable during the hold. After release, all 4 results arrive in order with none dropped or duplicated.
- out_ready toggled randomly 1000 cycles, in_valid random, in_data uniform in [0, 2q) -> scoreboard matches in_data mod q and tag order exactly.
- q=12289 (LOGQ=31 zero-extended), in_data = 2q = 24578 -> out_data = 12289 (truncated single subtraction), err=1. Pulse err_clr -> err=0. err_clr in the same cycle as a new violation (in_data = 30000) -> err=1.
- Assert rst_n=0 asynchronously with 2 items in flight and out_ready=0 -> out_valid=0 immediately, err=0. After deassert, a fresh input 7 emerges as 7 two cycles later.
- Back-to-back inputs with out_ready=1 for 64 cycles -> in_ready is constantly 1 and one result per cycle after the 2-cycle fill.
